// File: rtl/backprop_sequencer_if.sv
// Handshake/status bundle between the training sequencer and its host/datapath.
// The sequencer uses the slave modport; the host side (start/abort, forward-pass block) uses master.
interface backprop_sequencer_if #(
  parameter int SA_W = 4,
  parameter int EC_W = 7
);
  logic            start;
  logic            abort;
  logic            fwd_done;
  logic            conv;
  logic [SA_W-1:0] sample_addr;
  logic            fwd_start;
  logic            we;
  logic [EC_W-1:0] epoch_cnt;
  logic            busy;
  logic            done;
  logic            timeout_err;

  modport master (
    output start, abort, fwd_done, conv,
    input  sample_addr, fwd_start, we, epoch_cnt, busy, done, timeout_err
  );

  modport slave (
    input  start, abort, fwd_done, conv,
    output sample_addr, fwd_start, we, epoch_cnt, busy, done, timeout_err
  );
endinterface

// File: rtl/backprop_sequencer.sv
// Training-control FSM: per sample FETCH -> FWD -> WAIT_FWD -> SETTLE -> WRITE -> NEXT, counting epochs.
// Optional macro BACKPROP_EARLY_STOP_EN ends the run after an epoch in which every sample converged.
module backprop_sequencer #(
  parameter int NUM_SAMPLES = 16,
  parameter int EPOCHS      = 100,
  parameter int SETTLE_CYC  = 2,
  parameter int FWD_TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  backprop_sequencer_if.slave bus
);
  localparam int SA_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int EC_W  = $clog2(EPOCHS + 1);
  localparam int CMAX  = (FWD_TIMEOUT > SETTLE_CYC) ? FWD_TIMEOUT : SETTLE_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FWD, S_WAIT_FWD, S_SETTLE, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SA_W-1:0]  r_sample_addr;
  logic [EC_W-1:0]  r_epoch_cnt;
  logic             r_timeout_err;
  logic             w_abort, w_accept, w_tmo, w_settle_last;
  logic             w_last_sample, w_last_epoch, w_conv_stop;

  assign w_abort       = bus.abort && (r_state != S_IDLE);
  assign w_accept      = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_tmo         = (r_cnt == CNT_W'(FWD_TIMEOUT - 1));
  assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_last_sample = (r_sample_addr == SA_W'(NUM_SAMPLES - 1));
  assign w_last_epoch  = (r_epoch_cnt == EC_W'(EPOCHS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_FETCH;
      S_FETCH:    w_next = S_FWD;
      S_FWD:      w_next = S_WAIT_FWD;
      S_WAIT_FWD: if (bus.fwd_done) w_next = S_SETTLE;
                  else if (w_tmo)   w_next = S_IDLE;
      S_SETTLE:   if (w_settle_last) w_next = S_WRITE;
      S_WRITE:    w_next = S_NEXT;
      S_NEXT:     if (w_last_sample && (w_last_epoch || w_conv_stop)) w_next = S_DONE;
                  else w_next = S_FETCH;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    // abort outranks fwd_done and the timeout
    if (w_abort) w_next = S_IDLE;
  end

  // Shared wait/settle counter: runs only while parked in WAIT_FWD or SETTLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if ((r_state == S_WAIT_FWD || r_state == S_SETTLE) && (w_next == r_state))
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample_addr <= '0;
      r_epoch_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_sample_addr <= '0;
      r_epoch_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else if (!w_abort) begin
      if (r_state == S_WAIT_FWD && !bus.fwd_done && w_tmo)
        r_timeout_err <= 1'b1;
      if (r_state == S_NEXT) begin
        if (w_last_sample) begin
          r_sample_addr <= '0;
          r_epoch_cnt   <= r_epoch_cnt + 1'b1;
        end else begin
          r_sample_addr <= r_sample_addr + 1'b1;
        end
      end
    end
  end

`ifdef BACKPROP_EARLY_STOP_EN
  logic r_epoch_conv;

  // Cleared by any non-converged sample; re-armed at every epoch boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_epoch_conv <= 1'b0;
    else if (w_accept)
      r_epoch_conv <= 1'b1;
    else if (!w_abort && r_state == S_NEXT && w_last_sample)
      r_epoch_conv <= 1'b1;
    else if (!w_abort && r_state == S_SETTLE && w_settle_last)
      r_epoch_conv <= r_epoch_conv & bus.conv;
  end

  assign w_conv_stop = r_epoch_conv;
`else
  assign w_conv_stop = 1'b0;
`endif

  assign bus.sample_addr = r_sample_addr;
  assign bus.epoch_cnt   = r_epoch_cnt;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fwd_start   = (r_state == S_FWD)   && !bus.abort;
  assign bus.we          = (r_state == S_WRITE) && !bus.abort;
  assign bus.done        = (r_state == S_DONE)  && !bus.abort;
endmodule

// File: tb/tb_backprop_sequencer.sv
// Randomized bench for backprop_sequencer: expected pulse events are queued by the stimulus
// and checked by an independent monitor; a responder returns fwd_done after a random delay.
module tb_backprop_sequencer;
  localparam int NS   = 4;
  localparam int EP   = 2;
  localparam int SC   = 2;
  localparam int FT   = 8;
  localparam int SA_W = $clog2(NS);
  localparam int EC_W = $clog2(EP + 1);

  typedef struct {
    int kind;   // 0 fwd_start, 1 WE, 2 done
    int cyc;
    int addr;
    int ep;
  } ev_t;

  logic clk, rst_n;
  logic drv_start, noise_start, rsp_done, inj_done, inj_en;
  int   cyc, done_cnt, n_chk, n_fail;
  ev_t  exp_q[$];
  int   dq[$];

  backprop_sequencer_if #(.SA_W(SA_W), .EC_W(EC_W)) bus ();

  backprop_sequencer #(
    .NUM_SAMPLES(NS), .EPOCHS(EP), .SETTLE_CYC(SC), .FWD_TIMEOUT(FT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.start    = drv_start | noise_start;
  assign bus.fwd_done = rsp_done | inj_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  task automatic pop_ev(input int kind);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse kind=%0d cyc=%0d addr=%0d ep=%0d expected=none",
               kind, cyc, bus.sample_addr, bus.epoch_cnt);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.addr != int'(bus.sample_addr) ||
        e.ep != int'(bus.epoch_cnt)) begin
      n_fail++;
      $display("FAIL pulse actual kind=%0d cyc=%0d addr=%0d ep=%0d expected kind=%0d cyc=%0d addr=%0d ep=%0d",
               kind, cyc, bus.sample_addr, bus.epoch_cnt, e.kind, e.cyc, e.addr, e.ep);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.fwd_start) pop_ev(0);
    if (bus.we)        pop_ev(1);
    if (bus.done) begin
      pop_ev(2);
      done_cnt++;
    end
  end

  // Forward-pass responder: fwd_done d cycles after fwd_start (d=0 withholds it).
  initial forever begin
    int d;
    @(negedge clk);
    if (bus.fwd_start) begin
      if (dq.size() == 0) begin
        chk("delay_queue_empty", 0, 1);
        d = 1;
      end else d = dq.pop_front();
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #1 rsp_done = 1'b1;
        @(posedge clk);
        #1 rsp_done = 1'b0;
        if (inj_en && $urandom_range(0, 1) == 1) begin
          inj_done = 1'b1;   // stray pulse while in SETTLE
          @(posedge clk);
          #1 inj_done = 1'b0;
        end
      end
    end
  end

  // Stray start requests while a run is in progress.
  initial forever begin
    @(negedge clk);
    if (inj_en && bus.busy && $urandom_range(0, 3) == 0) begin
      noise_start = 1'b1;
      @(posedge clk);
      #1 noise_start = 1'b0;
    end
  end

  // stop_kind: 0 full run, 1 abort in WRITE of global sample stop_idx, 2 reset in its SETTLE
  task automatic run(input bit conv_v, input bit inj, input int stop_kind, input int stop_idx);
    int  k, t, d, tw, tl, ep_total, d0, lim, stop_t, stop_s, stop_e;
    bit  stopped;
    ep_total = EP;
`ifdef BACKPROP_EARLY_STOP_EN
    if (conv_v) ep_total = 1;
`endif
    stopped = 1'b0; stop_t = 0; stop_s = 0; stop_e = 0; tl = 0;
    bus.conv = conv_v;
    inj_en   = inj;
    k  = cyc;
    d0 = done_cnt;
    t  = k + 2;
    for (int e = 0; e < ep_total && !stopped; e++)
      for (int s = 0; s < NS && !stopped; s++) begin
        d = $urandom_range(1, 6);
        dq.push_back(d);
        exp_q.push_back(ev_t'{0, t, s, e});
        tw = t + d + SC + 1;
        if (stop_kind != 0 && e * NS + s == stop_idx) begin
          stopped = 1'b1;
          stop_t  = (stop_kind == 1) ? tw : t + d + 1;
          stop_s  = s;
          stop_e  = e;
        end else begin
          exp_q.push_back(ev_t'{1, tw, s, e});
          tl = tw;
          t  = tw + 3;
        end
      end
    if (!stopped) exp_q.push_back(ev_t'{2, tl + 2, 0, ep_total});

    drv_start = 1'b1;
    @(posedge clk);
    #1 drv_start = 1'b0;
    chk("fetch_busy", int'(bus.busy), 1);
    chk("start_clears_timeout", int'(bus.timeout_err), 0);
    chk("start_clears_addr", int'(bus.sample_addr), 0);
    chk("start_clears_epoch", int'(bus.epoch_cnt), 0);

    if (stop_kind == 0) begin
      lim = cyc + 600;
      while (done_cnt == d0 && cyc < lim) begin
        @(posedge clk); #1;
      end
      chk("done_seen", done_cnt - d0, 1);
      @(negedge clk);
      chk("end_busy", int'(bus.busy), 0);
      chk("end_epoch_cnt", int'(bus.epoch_cnt), ep_total);
      chk("end_sample_addr", int'(bus.sample_addr), 0);
      chk("end_queue_empty", exp_q.size(), 0);
    end else if (stop_kind == 1) begin
      wait_cyc(stop_t);
      bus.abort = 1'b1;
      #1 chk("abort_masks_we", int'(bus.we), 0);
      @(posedge clk);
      #1 bus.abort = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_addr", int'(bus.sample_addr), stop_s);
      chk("abort_epoch", int'(bus.epoch_cnt), stop_e);
      repeat (3) @(posedge clk);
      #1 chk("abort_stays_idle", int'(bus.busy), 0);
      chk("abort_queue_empty", exp_q.size(), 0);
    end else begin
      wait_cyc(stop_t);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_addr", int'(bus.sample_addr), 0);
      chk("rst_epoch", int'(bus.epoch_cnt), 0);
      chk("rst_pulses", int'({bus.fwd_start, bus.we, bus.done}), 0);
      chk("rst_timeout", int'(bus.timeout_err), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rst_queue_empty", exp_q.size(), 0);
    end
    inj_en   = 1'b0;
    bus.conv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_timeout();
    int t;
    dq.push_back(0);
    t = cyc + 2;
    exp_q.push_back(ev_t'{0, t, 0, 0});
    drv_start = 1'b1;
    @(posedge clk);
    #1 drv_start = 1'b0;
    wait_cyc(t + FT);
    chk("tmo_last_wait_busy", int'(bus.busy), 1);
    chk("tmo_not_yet", int'(bus.timeout_err), 0);
    @(posedge clk); #1;
    chk("tmo_idle", int'(bus.busy), 0);
    chk("tmo_set", int'(bus.timeout_err), 1);
    repeat (4) @(posedge clk);
    #1 chk("tmo_sticky", int'(bus.timeout_err), 1);
    chk("tmo_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; done_cnt = 0; n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    drv_start = 1'b0; noise_start = 1'b0; rsp_done = 1'b0; inj_done = 1'b0; inj_en = 1'b0;
    bus.abort = 1'b0;
    bus.conv  = 1'b0;
    #12;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_addr", int'(bus.sample_addr), 0);
    chk("reset_epoch", int'(bus.epoch_cnt), 0);
    chk("reset_pulses", int'({bus.fwd_start, bus.we, bus.done}), 0);
    chk("reset_timeout", int'(bus.timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start and abort together in IDLE must not launch a run
    drv_start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 drv_start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;

    run(1'b0, 1'b0, 0, 0);
    run(1'b0, 1'b1, 0, 0);
    run_timeout();
    run(1'b0, 1'b0, 0, 0);
    run(1'b0, 1'b0, 1, 2);
    run(1'b0, 1'b0, 2, 5);
    run(1'b0, 1'b0, 0, 0);
    run(1'b1, 1'b0, 0, 0);
    run(1'b0, 1'b1, 1, int'($urandom_range(0, NS * EP - 1)));
    run(1'b0, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
